parking_lot_controller: RTL and testbench

//  Parametrised N-spot parking manager with timed gate and request/grant handshake.

---
 rtl/parking_lot_controller.sv | 124 ++++++++++++
 tb/tb_parking_lot_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_lot_controller.sv
// N-spot parking manager: occupancy bitmap, lowest-free allocation, timed gate.
// Optional PARK_STATS_EN adds saturating total_entries/total_rejects counters.
module parking_lot_controller #(
  parameter int N_SPOTS = 4,
  parameter int DOOR_CYCLES = 8,
  localparam int SPOT_W = $clog2(N_SPOTS),
  localparam int CNT_W = $clog2(N_SPOTS + 1),
  localparam int TMR_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               entry_req,
  input  logic               exit_req,
  input  logic [SPOT_W-1:0]  exit_spot,
  output logic               entry_ack,
  output logic               entry_rej,
  output logic               exit_ack,
  output logic               exit_rej,
  output logic [SPOT_W-1:0]  assigned_spot,
  output logic [SPOT_W-1:0]  best_position,
  output logic [N_SPOTS-1:0] parking_spots,
  output logic [CNT_W-1:0]   capacity,
  output logic               full_led,
  output logic               door_open
`ifdef PARK_STATS_EN
  ,
  output logic [15:0]        total_entries,
  output logic [15:0]        total_rejects
`endif
);

  typedef enum logic {IDLE, DOOR} state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic             in_range;
  logic             exit_hit;

  assign in_range = (32'(exit_spot) < 32'(N_SPOTS));
  assign exit_hit = in_range && parking_spots[exit_spot];
  assign full_led = (capacity == '0);

  // Lowest-index free spot; 0 when every spot is taken.
  always_comb begin
    best_position = '0;
    for (int i = N_SPOTS - 1; i >= 0; i--) begin
      if (!parking_spots[i]) best_position = SPOT_W'(i);
    end
  end

  // Request arbitration, occupancy bookkeeping and door timer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      timer         <= '0;
      parking_spots <= '0;
      capacity      <= CNT_W'(N_SPOTS);
      assigned_spot <= '0;
      door_open     <= 1'b0;
      entry_ack     <= 1'b0;
      entry_rej     <= 1'b0;
      exit_ack      <= 1'b0;
      exit_rej      <= 1'b0;
    end else begin
      entry_ack <= 1'b0;
      entry_rej <= 1'b0;
      exit_ack  <= 1'b0;
      exit_rej  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (exit_req) begin
            if (exit_hit) begin
              parking_spots[exit_spot] <= 1'b0;
              capacity  <= capacity + CNT_W'(1);
              exit_ack  <= 1'b1;
              door_open <= 1'b1;
              timer     <= TMR_W'(DOOR_CYCLES - 1);
              state     <= DOOR;
            end else begin
              exit_rej <= 1'b1;
            end
          end else if (entry_req) begin
            if (capacity != '0) begin
              parking_spots[best_position] <= 1'b1;
              assigned_spot <= best_position;
              capacity  <= capacity - CNT_W'(1);
              entry_ack <= 1'b1;
              door_open <= 1'b1;
              timer     <= TMR_W'(DOOR_CYCLES - 1);
              state     <= DOOR;
            end else begin
              entry_rej <= 1'b1;
            end
          end
        end
        DOOR: begin
          if (timer == '0) begin
            door_open <= 1'b0;
            state     <= IDLE;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PARK_STATS_EN
  // Saturating event counters fed by the registered response pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      total_entries <= '0;
      total_rejects <= '0;
    end else begin
      if (entry_ack && total_entries != 16'hFFFF)
        total_entries <= total_entries + 16'd1;
      if ((entry_rej || exit_rej) && total_rejects != 16'hFFFF)
        total_rejects <= total_rejects + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_parking_lot_controller.sv
// Scoreboard bench for parking_lot_controller: directed scenarios then random
// traffic against a spot-array reference model; mid-door reset at the end.
module tb_parking_lot_controller;

  localparam int N = 4;
  localparam int DC = 8;
  localparam int SW = $clog2(N);
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          entry_req = 1'b0;
  logic          exit_req = 1'b0;
  logic [SW-1:0] exit_spot = '0;
  logic          entry_ack, entry_rej, exit_ack, exit_rej;
  logic [SW-1:0] assigned_spot, best_position;
  logic [N-1:0]  parking_spots;
  logic [CW-1:0] capacity;
  logic          full_led, door_open;
`ifdef PARK_STATS_EN
  logic [15:0]   total_entries, total_rejects;
`endif

  parking_lot_controller #(.N_SPOTS(N), .DOOR_CYCLES(DC)) dut (
    .clk(clk),
    .reset(reset),
    .entry_req(entry_req),
    .exit_req(exit_req),
    .exit_spot(exit_spot),
    .entry_ack(entry_ack),
    .entry_rej(entry_rej),
    .exit_ack(exit_ack),
    .exit_rej(exit_rej),
    .assigned_spot(assigned_spot),
    .best_position(best_position),
    .parking_spots(parking_spots),
    .capacity(capacity),
    .full_led(full_led),
    .door_open(door_open)
`ifdef PARK_STATS_EN
    ,
    .total_entries(total_entries),
    .total_rejects(total_rejects)
`endif
  );

  always #5 clk = ~clk;

  int vec = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    vec++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // kind: 0 entry_ack, 1 entry_rej, 2 exit_ack, 3 exit_rej
  typedef struct {
    int          kind;
    int          spot;
    logic [N-1:0] map;
    int          cap;
    int          best;
  } exp_t;

  exp_t sbq[$];

  bit occ[N];
  int m_entries = 0;
  int m_rejects = 0;

  function automatic int m_free();
    int f = 0;
    foreach (occ[i]) if (!occ[i]) f++;
    return f;
  endfunction

  function automatic int m_lowest();
    for (int i = 0; i < N; i++) if (!occ[i]) return i;
    return 0;
  endfunction

  function automatic logic [N-1:0] m_map();
    logic [N-1:0] m = '0;
    foreach (occ[i]) m[i] = occ[i];
    return m;
  endfunction

  task automatic model_exit(input int spot);
    exp_t e;
    if (spot < N && occ[spot]) begin
      occ[spot] = 1'b0;
      e.kind = 2;
    end else begin
      e.kind = 3;
      m_rejects++;
    end
    e.spot = 0;
    e.map = m_map();
    e.cap = m_free();
    e.best = m_lowest();
    sbq.push_back(e);
  endtask

  task automatic model_entry();
    exp_t e;
    if (m_free() > 0) begin
      e.spot = m_lowest();
      occ[e.spot] = 1'b1;
      e.kind = 0;
      m_entries++;
    end else begin
      e.spot = 0;
      e.kind = 1;
      m_rejects++;
    end
    e.map = m_map();
    e.cap = m_free();
    e.best = m_lowest();
    sbq.push_back(e);
  endtask

  // Monitor: pops one expectation per response pulse.
  always @(negedge clk) begin
    if (reset && (entry_ack | entry_rej | exit_ack | exit_rej)) begin
      if (sbq.size() == 0) begin
        chk("unexpected_pulse",
            {entry_ack, entry_rej, exit_ack, exit_rej}, 0);
      end else begin
        exp_t e;
        int k;
        e = sbq.pop_front();
        k = -1;
        if ($countones({entry_ack, entry_rej, exit_ack, exit_rej}) == 1)
          k = entry_ack ? 0 : entry_rej ? 1 : exit_ack ? 2 : 3;
        chk("resp_kind", k, e.kind);
        if (e.kind == 0) chk("assigned_spot", assigned_spot, e.spot);
        chk("parking_spots", parking_spots, e.map);
        chk("capacity", capacity, e.cap);
        chk("full_led", full_led, (e.cap == 0) ? 1 : 0);
        chk("best_position", best_position, e.best);
      end
    end
  end

  task automatic do_txn(input bit en, input bit ex, input int spot);
    int nresp = 0;
    bit got;
    entry_req = en;
    exit_req = ex;
    exit_spot = SW'(spot);
    if (ex) begin model_exit(spot); nresp++; end
    if (en) begin model_entry(); nresp++; end
    for (int k = 0; k < nresp; k++) begin
      got = 0;
      for (int c = 0; c < 6 && !got; c++) begin
        @(negedge clk);
        if (entry_ack | entry_rej | exit_ack | exit_rej) got = 1;
      end
      if (!got) begin
        chk("resp_timeout", 0, 1);
        entry_req = 0;
        exit_req = 0;
        sbq.delete();
        return;
      end
      if (exit_ack | exit_rej) exit_req = 0;
      if (entry_ack | entry_rej) entry_req = 0;
      if (entry_ack | exit_ack) begin
        int cnt = 0;
        while (door_open === 1'b1 && cnt < 40) begin
          cnt++;
          @(negedge clk);
        end
        chk("door_len", cnt, DC);
      end else begin
        chk("door_closed_on_rej", door_open, 0);
      end
    end
  endtask

  initial begin
    foreach (occ[i]) occ[i] = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_parking_spots", parking_spots, 0);
    chk("rst_capacity", capacity, N);
    chk("rst_best_position", best_position, 0);
    chk("rst_full_led", full_led, 0);
    chk("rst_door_open", door_open, 0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < N; i++) do_txn(1, 0, 0);
    chk("full_after_fill", full_led, 1);
    do_txn(1, 0, 0);
    chk("cap_after_rej", capacity, 0);
    do_txn(0, 1, 2);
    chk("map_after_exit2", parking_spots, 4'b1011);
    do_txn(1, 0, 0);
    chk("reassigned_spot2", assigned_spot, 2);
    do_txn(1, 1, 1);
    do_txn(0, 1, 1);
    do_txn(0, 1, 1);

    for (int t = 0; t < 150; t++) begin
      int r = $urandom_range(0, 2);
      int s = $urandom_range(0, N - 1);
      do_txn(r != 1, r != 0, s);
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
`ifdef PARK_STATS_EN
    chk("total_entries", total_entries, m_entries);
    chk("total_rejects", total_rejects, m_rejects);
`endif

    // Mid-door reset: open the gate, then pull reset a few cycles in.
    if (m_free() == 0) do_txn(0, 1, 0);
    entry_req = 1'b1;
    model_entry();
    for (int c = 0; c < 6 && !entry_ack; c++) @(negedge clk);
    chk("pre_reset_ack", entry_ack, 1);
    entry_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_door", door_open, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_reset_door", door_open, 0);
    chk("mid_reset_map", parking_spots, 0);
    chk("mid_reset_cap", capacity, N);
`ifdef PARK_STATS_EN
    chk("mid_reset_entries", total_entries, 0);
    chk("mid_reset_rejects", total_rejects, 0);
`endif
    foreach (occ[i]) occ[i] = 1'b0;
    m_entries = 0;
    m_rejects = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_txn(1, 0, 0);
    chk("post_reset_map", parking_spots, 4'b0001);
    chk("sb_final", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "timeout");
  end

endmodule
